// File: rtl/dcache_ace_checker.sv
// rtl/dcache_ace_checker.sv - passive load/store/routing/snoop scoreboard for the ACE dcache bench
package dcache_ace_checker_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic        aw_valid;
        logic [63:0] aw_addr;
        logic        w_valid;
        logic        ar_valid;
        logic [63:0] ar_addr;
    } ace_m2s_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
    } ace_s2m_t;

    typedef struct packed {
        logic ac_valid;
        logic cr_ready;
    } snoop_req_t;

    typedef struct packed {
        logic ac_ready;
        logic cr_valid;
    } snoop_resp_t;

endpackage

module dcache_ace_checker
    import dcache_ace_checker_pkg::*;
#(
    parameter int unsigned NR_CPU_PORTS    = 3,
    parameter logic [63:0] CACHE_BASE_ADDR = 64'h0,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned LQ_DEPTH        = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_transaction_i,
    output logic          check_done_o,
    input  dcache_req_i_t req_ports_i [NR_CPU_PORTS],
    input  dcache_req_o_t req_ports_o [NR_CPU_PORTS],
    input  ace_m2s_t      axi_data_o,
    input  ace_s2m_t      axi_data_i,
    input  ace_m2s_t      axi_bypass_o,
    input  ace_s2m_t      axi_bypass_i,
    input  snoop_req_t    snoop_req_i,
    input  snoop_resp_t   snoop_resp_o,
    output logic          err_o,
    output logic [15:0]   err_cnt_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LQ_DEPTH + 1);
    localparam logic [63:0] MEM_END  = CACHE_BASE_ADDR + 64'(MEM_WORDS) * 64'd8;
    localparam logic [CNT_W-1:0] LQ_FULL  = CNT_W'(LQ_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LQ_DEPTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [63:0] req_addr(input dcache_req_i_t r);
        return 64'({r.address_tag, r.address_index});
    endfunction

    function automatic logic in_shadow(input logic [63:0] a);
        return (a >= CACHE_BASE_ADDR) && (a < MEM_END);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_LAST : p - PTR_W'(1);
    endfunction

    logic [63:0]             mem_data_q [MEM_WORDS];
    logic [7:0]              mem_vld_q  [MEM_WORDS];
    logic [63:0]             port_addr  [NR_CPU_PORTS];
    logic [IDX_W-1:0]        st_word    [NR_CPU_PORTS];
    logic [NR_CPU_PORTS-1:0] st_hit;

    logic [DCACHE_INDEX_WIDTH-1:0] lq_idx_q [NR_CPU_PORTS][LQ_DEPTH];
    logic [DCACHE_TAG_WIDTH-1:0]   lq_tag_q [NR_CPU_PORTS][LQ_DEPTH];
    logic [7:0]                    lq_be_q  [NR_CPU_PORTS][LQ_DEPTH];
    logic [CNT_W-1:0] lq_cnt_q [NR_CPU_PORTS];
    logic [CNT_W-1:0] lq_cnt_d [NR_CPU_PORTS];
    logic [PTR_W-1:0] lq_wr_q  [NR_CPU_PORTS];
    logic [PTR_W-1:0] lq_wr_d  [NR_CPU_PORTS];
    logic [PTR_W-1:0] lq_rd_q  [NR_CPU_PORTS];
    logic [PTR_W-1:0] lq_rd_d  [NR_CPU_PORTS];
    logic [PTR_W-1:0] lq_tail  [NR_CPU_PORTS];
    logic [PTR_W-1:0] lq_slot  [NR_CPU_PORTS];
    logic [NR_CPU_PORTS-1:0] tag_pend_q, tag_pend_d;
    logic [NR_CPU_PORTS-1:0] tag_fill, lq_kill, lq_pop, lq_push, load_gnt;
    logic [NR_CPU_PORTS-1:0] lq_full_err, lq_empty_err, rd_mismatch;
    logic [63:0]             head_addr [NR_CPU_PORTS];
    logic [IDX_W-1:0]        head_word [NR_CPU_PORTS];

    logic       route_err, snp_err, ac_hs, cr_hs, err_any, bus_quiet;
    logic [3:0] snp_cnt_q, snp_cnt_d;
    logic       err_q;
    logic [15:0] err_cnt_q;
    logic [1:0] state_q, state_d;
    logic       drain_q, drain_d;

    // Decode granted stores that land inside the shadowed cacheable window
    always_comb begin
        for (int p = 0; p < NR_CPU_PORTS; p++) begin
            port_addr[p] = req_addr(req_ports_i[p]);
            st_word[p]   = port_addr[p][3 +: IDX_W];
            st_hit[p]    = req_ports_i[p].data_req && req_ports_i[p].data_we &&
                           req_ports_o[p].data_gnt && req_ports_i[p].tag_valid &&
                           in_shadow(port_addr[p]);
        end
    end

    // Shadow data bytes; validity lives in mem_vld_q so the data needs no reset
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_CPU_PORTS; p++) begin
            for (int b = 0; b < 8; b++) begin
                if (st_hit[p] && req_ports_i[p].data_be[b]) begin
                    mem_data_q[st_word[p]][8*b +: 8] <= req_ports_i[p].data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Per-byte valid bits, set bit-wise so two ports hitting one word both land
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < MEM_WORDS; w++) begin
                mem_vld_q[w] <= '0;
            end
        end else begin
            for (int p = 0; p < NR_CPU_PORTS; p++) begin
                for (int b = 0; b < 8; b++) begin
                    if (st_hit[p] && req_ports_i[p].data_be[b]) begin
                        mem_vld_q[st_word[p]][b] <= 1'b1;
                    end
                end
            end
        end
    end

    // Load FIFO bookkeeping: kill drops the newest entry, rvalid pops the oldest, grant pushes
    always_comb begin
        for (int p = 0; p < NR_CPU_PORTS; p++) begin
            lq_cnt_d[p]     = lq_cnt_q[p];
            lq_wr_d[p]      = lq_wr_q[p];
            lq_rd_d[p]      = lq_rd_q[p];
            lq_tail[p]      = ptr_dec(lq_wr_q[p]);
            tag_fill[p]     = tag_pend_q[p] && !req_ports_i[p].kill_req;
            lq_kill[p]      = tag_pend_q[p] && req_ports_i[p].kill_req;
            lq_pop[p]       = req_ports_o[p].data_rvalid && (lq_cnt_q[p] != '0) &&
                              !(lq_kill[p] && (lq_cnt_q[p] == CNT_W'(1)));
            lq_empty_err[p] = req_ports_o[p].data_rvalid && !lq_pop[p];
            if (lq_kill[p]) begin
                lq_wr_d[p]  = lq_tail[p];
                lq_cnt_d[p] = lq_cnt_d[p] - CNT_W'(1);
            end
            if (lq_pop[p]) begin
                lq_rd_d[p]  = ptr_inc(lq_rd_q[p]);
                lq_cnt_d[p] = lq_cnt_d[p] - CNT_W'(1);
            end
            load_gnt[p]    = req_ports_i[p].data_req && !req_ports_i[p].data_we &&
                             req_ports_o[p].data_gnt;
            lq_full_err[p] = load_gnt[p] && (lq_cnt_d[p] == LQ_FULL);
            lq_push[p]     = load_gnt[p] && !lq_full_err[p];
            lq_slot[p]     = lq_wr_d[p];
            if (lq_push[p]) begin
                lq_wr_d[p]  = ptr_inc(lq_wr_d[p]);
                lq_cnt_d[p] = lq_cnt_d[p] + CNT_W'(1);
            end
            tag_pend_d[p] = lq_push[p];
        end
    end

    // Compare returned load data with the shadow; a same-cycle store overrides the stored byte
    always_comb begin
        logic [DCACHE_TAG_WIDTH-1:0] head_tag;
        logic [7:0]                  exp_byte;
        logic                        exp_vld;
        head_tag = '0;
        exp_byte = '0;
        exp_vld  = 1'b0;
        for (int p = 0; p < NR_CPU_PORTS; p++) begin
            head_tag = (tag_fill[p] && (lq_rd_q[p] == lq_tail[p])) ?
                       req_ports_i[p].address_tag : lq_tag_q[p][lq_rd_q[p]];
            head_addr[p]   = 64'({head_tag, lq_idx_q[p][lq_rd_q[p]]});
            head_word[p]   = head_addr[p][3 +: IDX_W];
            rd_mismatch[p] = 1'b0;
            for (int b = 0; b < 8; b++) begin
                exp_byte = mem_data_q[head_word[p]][8*b +: 8];
                exp_vld  = mem_vld_q[head_word[p]][b];
                for (int q = 0; q < NR_CPU_PORTS; q++) begin
                    if (st_hit[q] && (st_word[q] == head_word[p]) && req_ports_i[q].data_be[b]) begin
                        exp_byte = req_ports_i[q].data_wdata[8*b +: 8];
                        exp_vld  = 1'b1;
                    end
                end
                if (lq_pop[p] && in_shadow(head_addr[p]) && lq_be_q[p][lq_rd_q[p]][b] &&
                    exp_vld && (req_ports_o[p].data_rdata[8*b +: 8] != exp_byte)) begin
                    rd_mismatch[p] = 1'b1;
                end
            end
        end
    end

    // Load FIFO pointers and counts
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NR_CPU_PORTS; p++) begin
                lq_cnt_q[p] <= '0;
                lq_wr_q[p]  <= '0;
                lq_rd_q[p]  <= '0;
            end
            tag_pend_q <= '0;
        end else begin
            for (int p = 0; p < NR_CPU_PORTS; p++) begin
                lq_cnt_q[p] <= lq_cnt_d[p];
                lq_wr_q[p]  <= lq_wr_d[p];
                lq_rd_q[p]  <= lq_rd_d[p];
            end
            tag_pend_q <= tag_pend_d;
        end
    end

    // Load FIFO entry payload; stale slots are never read because counts gate them
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_CPU_PORTS; p++) begin
            if (lq_push[p]) begin
                lq_idx_q[p][lq_slot[p]] <= req_ports_i[p].address_index;
                lq_be_q[p][lq_slot[p]]  <= req_ports_i[p].data_be;
            end
            if (tag_fill[p]) begin
                lq_tag_q[p][lq_tail[p]] <= req_ports_i[p].address_tag;
            end
        end
    end

    // Cacheable traffic must use the data bus, non-cacheable traffic the bypass bus
    always_comb begin
        route_err = 1'b0;
        if (axi_data_o.ar_valid && axi_data_i.ar_ready && (axi_data_o.ar_addr < CACHE_BASE_ADDR)) route_err = 1'b1;
        if (axi_data_o.aw_valid && axi_data_i.aw_ready && (axi_data_o.aw_addr < CACHE_BASE_ADDR)) route_err = 1'b1;
        if (axi_bypass_o.ar_valid && axi_bypass_i.ar_ready && (axi_bypass_o.ar_addr >= CACHE_BASE_ADDR)) route_err = 1'b1;
        if (axi_bypass_o.aw_valid && axi_bypass_i.aw_ready && (axi_bypass_o.aw_addr >= CACHE_BASE_ADDR)) route_err = 1'b1;
    end

    // Outstanding snoop tracking; counter holds at its limits when flagging an error
    always_comb begin
        ac_hs     = snoop_req_i.ac_valid && snoop_resp_o.ac_ready;
        cr_hs     = snoop_resp_o.cr_valid && snoop_req_i.cr_ready;
        snp_cnt_d = snp_cnt_q;
        snp_err   = 1'b0;
        if (ac_hs && !cr_hs) begin
            if (snp_cnt_q == 4'hF) snp_err = 1'b1;
            else                   snp_cnt_d = snp_cnt_q + 4'd1;
        end else if (cr_hs && !ac_hs) begin
            if (snp_cnt_q == 4'h0) snp_err = 1'b1;
            else                   snp_cnt_d = snp_cnt_q - 4'd1;
        end
    end

    assign err_any = (|lq_full_err) || (|lq_empty_err) || (|rd_mismatch) || route_err || snp_err;

    // Sticky error flag and saturating error counter, one increment per cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            snp_cnt_q <= '0;
        end else begin
            snp_cnt_q <= snp_cnt_d;
            if (err_any) begin
                err_q <= 1'b1;
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // A cycle is quiet once nothing is outstanding after this cycle's updates and no bus is busy
    always_comb begin
        bus_quiet = !(axi_data_o.ar_valid || axi_data_o.aw_valid || axi_data_o.w_valid ||
                      axi_bypass_o.ar_valid || axi_bypass_o.aw_valid || axi_bypass_o.w_valid) &&
                    (snp_cnt_d == 4'h0);
        for (int p = 0; p < NR_CPU_PORTS; p++) begin
            if ((lq_cnt_d[p] != '0) || req_ports_i[p].data_req) bus_quiet = 1'b0;
        end
    end

    // Round FSM: two consecutive quiet cycles in RUN end the round with a one-cycle DONE
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                drain_d = 1'b0;
                if (start_transaction_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_transaction_i) begin
                    drain_d = 1'b0;
                end else if (bus_quiet) begin
                    if (drain_q) begin
                        state_d = ST_DONE;
                        drain_d = 1'b0;
                    end else begin
                        drain_d = 1'b1;
                    end
                end else begin
                    drain_d = 1'b0;
                end
            end
            ST_DONE: begin
                drain_d = 1'b0;
                state_d = start_transaction_i ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                drain_d = 1'b0;
            end
        endcase
    end

    // FSM state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    assign check_done_o = (state_q == ST_DONE);
    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_dcache_ace_checker.sv
// tb/tb_dcache_ace_checker.sv - randomized self-checking bench for dcache_ace_checker
module tb_dcache_ace_checker;
    import dcache_ace_checker_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam int MEMW = 1024;
    localparam int LQ   = 4;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  be;
    } ld_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          check_done_o;
    logic          err_o;
    logic [15:0]   err_cnt_o;
    dcache_req_i_t req_i [3];
    dcache_req_o_t req_o [3];
    ace_m2s_t      dat_m2s, byp_m2s;
    ace_s2m_t      dat_s2m, byp_s2m;
    snoop_req_t    snp_req;
    snoop_resp_t   snp_resp;

    logic [7:0] mdl_mem [logic [63:0]];
    ld_t        mdl_lq [3][$];
    int         exp_err = 0;
    int         pend_snp = 0;
    int         checks = 0;
    int         errors = 0;

    dcache_ace_checker #(
        .NR_CPU_PORTS   (3),
        .CACHE_BASE_ADDR(BASE),
        .MEM_WORDS      (MEMW),
        .LQ_DEPTH       (LQ)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_transaction_i(start),
        .check_done_o       (check_done_o),
        .req_ports_i        (req_i),
        .req_ports_o        (req_o),
        .axi_data_o         (dat_m2s),
        .axi_data_i         (dat_s2m),
        .axi_bypass_o       (byp_m2s),
        .axi_bypass_i       (byp_s2m),
        .snoop_req_i        (snp_req),
        .snoop_resp_o       (snp_resp),
        .err_o              (err_o),
        .err_cnt_o          (err_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic in_shadow(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(MEMW) * 64'd8);
    endfunction

    function automatic logic [63:0] align(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

    function automatic void mdl_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] k;
        if (in_shadow(align(a))) begin
            for (int b = 0; b < 8; b++) begin
                k = align(a) + 64'(b);
                if (be[b]) mdl_mem[k] = d[8*b +: 8];
            end
        end
    endfunction

    function automatic logic mdl_rvalid(input int p, input logic [63:0] d);
        ld_t e;
        logic [63:0] k;
        logic bad;
        if (mdl_lq[p].size() == 0) return 1'b1;
        e = mdl_lq[p].pop_front();
        bad = 1'b0;
        if (in_shadow(e.addr)) begin
            for (int b = 0; b < 8; b++) begin
                k = e.addr + 64'(b);
                if (e.be[b] && mdl_mem.exists(k) && (mdl_mem[k] != d[8*b +: 8])) bad = 1'b1;
            end
        end
        return bad;
    endfunction

    function automatic logic [63:0] mdl_good_data(input int p);
        logic [63:0] d;
        logic [63:0] k;
        d = {$urandom, $urandom};
        if (mdl_lq[p].size() != 0) begin
            for (int b = 0; b < 8; b++) begin
                k = mdl_lq[p][0].addr + 64'(b);
                if (mdl_mem.exists(k)) d[8*b +: 8] = mdl_mem[k];
            end
        end
        return d;
    endfunction

    function automatic logic [63:0] rnd_addr();
        int k;
        k = int'($urandom_range(0, 19));
        if (k < 16) return BASE + 64'(8 * k);
        if (k < 18) return BASE - 64'(8 * (k - 15));
        return BASE + 64'(MEMW) * 64'd8 + 64'(8 * (k - 18));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int p = 0; p < 3; p++) begin
            req_i[p] = '0;
            req_o[p] = '0;
        end
        dat_m2s  = '0;
        dat_s2m  = '0;
        byp_m2s  = '0;
        byp_s2m  = '0;
        snp_req  = '0;
        snp_resp = '0;
        start    = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        mdl_mem.delete();
        for (int p = 0; p < 3; p++) mdl_lq[p].delete();
        exp_err  = 0;
        pend_snp = 0;
    endtask

    task automatic op_store(input int p, input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        clr();
        req_i[p].address_index = a[11:0];
        req_i[p].address_tag   = a[55:12];
        req_i[p].data_req      = 1'b1;
        req_i[p].data_we       = 1'b1;
        req_i[p].data_wdata    = d;
        req_i[p].data_be       = be;
        req_i[p].tag_valid     = 1'b1;
        req_o[p].data_gnt      = 1'b1;
        mdl_store(a, d, be);
        step();
        clr();
    endtask

    task automatic op_load(input int p, input logic [63:0] a, input logic [7:0] be, input logic kill);
        clr();
        req_i[p].address_index = a[11:0];
        req_i[p].data_req      = 1'b1;
        req_i[p].data_be       = be;
        req_o[p].data_gnt      = 1'b1;
        step();
        clr();
        req_i[p].address_tag = a[55:12];
        req_i[p].tag_valid   = 1'b1;
        req_i[p].kill_req    = kill;
        step();
        clr();
        if (mdl_lq[p].size() >= LQ) exp_err++;
        else if (!kill) mdl_lq[p].push_back('{addr: align(a), be: be});
    endtask

    task automatic op_rvalid(input int p, input logic [63:0] d);
        clr();
        req_o[p].data_rvalid = 1'b1;
        req_o[p].data_rdata  = d;
        if (mdl_rvalid(p, d)) exp_err++;
        step();
        clr();
    endtask

    task automatic op_axi(input logic bypass, input logic is_aw, input logic [63:0] a, input logic hs);
        ace_m2s_t m;
        ace_s2m_t s;
        clr();
        m = '0;
        s = '0;
        if (is_aw) begin
            m.aw_valid = 1'b1; m.aw_addr = a; m.w_valid = 1'b1; s.aw_ready = hs;
        end else begin
            m.ar_valid = 1'b1; m.ar_addr = a; s.ar_ready = hs;
        end
        if (bypass) begin byp_m2s = m; byp_s2m = s; end
        else        begin dat_m2s = m; dat_s2m = s; end
        if (hs && ((bypass && a >= BASE) || (!bypass && a < BASE))) exp_err++;
        step();
        clr();
    endtask

    task automatic op_ac();
        clr();
        snp_req.ac_valid  = 1'b1;
        snp_resp.ac_ready = 1'b1;
        if (pend_snp == 15) exp_err++;
        else pend_snp++;
        step();
        clr();
    endtask

    task automatic op_cr();
        clr();
        snp_resp.cr_valid = 1'b1;
        snp_req.cr_ready  = 1'b1;
        if (pend_snp == 0) exp_err++;
        else pend_snp--;
        step();
        clr();
    endtask

    initial begin
        logic [63:0] a, d;
        logic [7:0]  be;
        int r, p;

        clr();
        do_reset();
        check_eq("rst_err", 64'(err_o), 64'd0);
        check_eq("rst_cnt", 64'(err_cnt_o), 64'd0);
        check_eq("rst_done", 64'(check_done_o), 64'd0);

        op_store(0, BASE + 64'd8, 64'hDEADBEEF_01234567, 8'hFF);
        op_load(1, BASE + 64'd8, 8'hFF, 1'b0);
        op_rvalid(1, 64'hDEADBEEF_01234567);
        check_eq("load_match_cnt", 64'(err_cnt_o), 64'd0);

        op_load(1, BASE + 64'd8, 8'hFF, 1'b0);
        op_rvalid(1, 64'hDEADBEEF_01234568);
        check_eq("load_mismatch_err", 64'(err_o), 64'd1);
        check_eq("load_mismatch_cnt", 64'(err_cnt_o), 64'(exp_err));

        op_axi(1'b0, 1'b0, BASE - 64'd8, 1'b1);
        check_eq("route_data_low", 64'(err_cnt_o), 64'(exp_err));
        op_axi(1'b1, 1'b0, BASE - 64'd8, 1'b1);
        check_eq("route_bypass_low", 64'(err_cnt_o), 64'(exp_err));
        op_axi(1'b1, 1'b1, BASE, 1'b1);
        check_eq("route_bypass_base", 64'(err_cnt_o), 64'(exp_err));

        op_ac(); op_ac(); op_cr(); op_cr();
        check_eq("snoop_balanced", 64'(err_cnt_o), 64'(exp_err));
        op_cr();
        check_eq("snoop_extra_cr", 64'(err_cnt_o), 64'(exp_err));

        op_store(0, BASE + 64'd16, 64'h0102_0304_0506_0708, 8'hFF);
        op_load(2, BASE + 64'd16, 8'hFF, 1'b0);
        clr();
        req_i[0].address_index = 12'(BASE + 64'd16);
        req_i[0].address_tag   = 44'((BASE + 64'd16) >> 12);
        req_i[0].data_req      = 1'b1;
        req_i[0].data_we       = 1'b1;
        req_i[0].data_wdata    = 64'hA5A5_0000_FFFF_1234;
        req_i[0].data_be       = 8'hFF;
        req_i[0].tag_valid     = 1'b1;
        req_o[0].data_gnt      = 1'b1;
        req_o[2].data_rvalid   = 1'b1;
        req_o[2].data_rdata    = 64'hA5A5_0000_FFFF_1234;
        mdl_store(BASE + 64'd16, 64'hA5A5_0000_FFFF_1234, 8'hFF);
        if (mdl_rvalid(2, 64'hA5A5_0000_FFFF_1234)) exp_err++;
        step();
        clr();
        check_eq("store_wins", 64'(err_cnt_o), 64'(exp_err));

        op_load(0, BASE + 64'd24, 8'h0F, 1'b1);
        op_rvalid(0, 64'h0);
        check_eq("kill_then_rvalid", 64'(err_cnt_o), 64'(exp_err));

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            p = int'($urandom_range(0, 2));
            a = rnd_addr();
            if (r < 30) begin
                d  = {$urandom, $urandom};
                be = 8'($urandom_range(1, 255));
                op_store(p, a, d, be);
            end else if (r < 55) begin
                be = 8'($urandom_range(1, 255));
                op_load(p, a, be, ($urandom_range(0, 9) == 0));
            end else if (r < 80) begin
                d = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : mdl_good_data(p);
                op_rvalid(p, d);
            end else if (r < 90) begin
                op_axi(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, ($urandom_range(0, 3) != 0));
            end else begin
                if ($urandom_range(0, 9) < 6) op_ac();
                else op_cr();
            end
            check_eq("rnd_cnt", 64'(err_cnt_o), 64'(exp_err));
        end
        check_eq("rnd_sticky", 64'(err_o), 64'(exp_err != 0));

        op_store(0, BASE + 64'd32, 64'h1111_1111_1111_1111, 8'hFF);
        do_reset();
        check_eq("rst2_cnt", 64'(err_cnt_o), 64'd0);
        check_eq("rst2_err", 64'(err_o), 64'd0);

        clr();
        start = 1'b1;
        step();
        clr();
        op_load(0, BASE + 64'd32, 8'hFF, 1'b0);
        op_load(1, BASE + 64'd32, 8'hFF, 1'b0);
        op_load(2, BASE + 64'd40, 8'hFF, 1'b0);
        op_rvalid(0, 64'h2222_2222_2222_2222);
        check_eq("done_r1", 64'(check_done_o), 64'd0);
        op_rvalid(1, 64'h2222_2222_2222_2222);
        check_eq("done_r2", 64'(check_done_o), 64'd0);
        op_rvalid(2, 64'h3333_3333_3333_3333);
        check_eq("done_r3", 64'(check_done_o), 64'd0);
        step();
        check_eq("done_pulse", 64'(check_done_o), 64'd1);
        step();
        check_eq("done_after", 64'(check_done_o), 64'd0);
        check_eq("cleared_shadow_cnt", 64'(err_cnt_o), 64'(exp_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
